stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Control FSM and BCD time-keeper for the stopwatch, sitting between the clock divider and the 7-segment display driver.
- Consumes single-cycle tick enables derived from the divider: 1 Hz count, 2 Hz blink, 5 Hz adjust.
- Consumes debounced button pulses and switches.
- Sequences run/pause/clear/adjust and produces MM:SS BCD digits plus per-digit blank mask.

Parameters:
- SEC_MOD, 60, seconds field modulus (wrap SEC_MOD-1 -> 0).
- MIN_MOD, 60, minutes field modulus.
- BLINK_EN, 1, 1 = blank selected field in ADJUST on blink phase; 0 = never blank.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse, count enable.
- tick_2hz  in  1  one-cycle pulse, toggles blink phase.
- tick_adj  in  1  one-cycle pulse (5 Hz), adjust-increment enable.
- pause_btn  in  1  one-cycle debounced pulse, run/pause toggle.
- clr_btn  in  1  one-cycle debounced pulse, clear to 00:00.
- adj_sw  in  1  level; 1 = adjust mode.
- sel_sw  in  1  level; 0 = adjust minutes, 1 = adjust seconds.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits.
- blank  out  4  {min_tens, min_ones, sec_tens, sec_ones} blank mask; 1 = blank.
- running  out  1  high in RUNNING.
- state  out  2  current FSM state.
- wrap  out  1  one-cycle pulse on 59:59 -> 00:00 rollover while RUNNING.

Behaviour:
- Reset values:
  - state = STOPPED.
  - All digits = 0.
  - blank = 0, running = 0, wrap = 0.
  - blink phase = 0.
- All outputs registered; effect of any input visible on the cycle after it is sampled (latency 1).
- States: STOPPED=0, RUNNING=1, PAUSED=2, ADJUST=3.
- Per-cycle priority: rst > clr_btn > adj_sw > pause_btn > tick_1hz.
- clr_btn:
  - Digits become 00:00.
  - If adj_sw=0, state -> STOPPED; if adj_sw=1, state stays ADJUST.
  - A same-cycle tick_1hz or tick_adj is discarded.
- adj_sw=1 from any state: -> ADJUST, held while adj_sw=1; pause_btn ignored.
- adj_sw falling (in ADJUST with adj_sw=0): -> PAUSED, values kept.
- pause_btn transitions:
  - STOPPED -> RUNNING.
  - RUNNING -> PAUSED.
  - PAUSED -> RUNNING.
- tick_1hz counts only if state is RUNNING in the sampling cycle. A same-cycle pause_btn still counts that tick, then changes state.
- Counting:
  - Seconds increment; SEC_MOD-1 -> 0 carries into minutes.
  - Minutes MIN_MOD-1 -> 0 on carry; 59:59 -> 00:00 asserts wrap for exactly one cycle.
- Arithmetic: each field is a two-digit BCD counter.
  - Ones digit 9 -> 0 increments tens.
  - Field compare at MOD-1 in BCD, so no binary intermediate is needed.
- ADJUST increments:
  - On tick_adj, the selected field increments modulo its MOD with no carry into the other field.
  - tick_1hz is ignored.
  - sel_sw change takes effect on the next tick_adj.
- Blink phase:
  - Toggles on every tick_2hz in all states.
  - Cleared to 0 on entry to ADJUST, so the field is visible for the first half period.
- blank:
  - In ADJUST with BLINK_EN=1 and phase=1, the two bits of the selected field are 1.
  - Otherwise blank = 0.
- Simultaneous tick_adj and tick_2hz: both take effect.
- rst mid-operation returns to reset values on the next edge regardless of other inputs.

Decomposition:
- Package stopwatch_pkg:
  - State encoding constants (STOPPED/RUNNING/PAUSED/ADJUST).
  - SEC_MOD/MIN_MOD defaults.
  - BCD digit width constant 4.
- One sub-module, bcd_mod_counter: two-digit BCD counter with parameter MOD.
  - Inputs clk, rst, clr, inc.
  - Outputs tens, ones, carry (combinational, asserted when inc and value = MOD-1).
  - Instantiated once for seconds, once for minutes.
  - The minutes inc is the seconds carry in RUNNING, and tick_adj & ~sel_sw in ADJUST.

Test Plan:
- Reset, pause_btn, 75 tick_1hz -> running=1, display 01:15; pause_btn then 5 ticks -> still 01:15, state=PAUSED.
- Preload via ADJUST to 59:58, exit, pause_btn, 2 tick_1hz -> 00:00 with wrap high exactly one cycle after the second tick.
- adj_sw=1, sel_sw=1, 61 tick_adj from 00:00 -> seconds 01, minutes unchanged 00 (no carry); sel_sw=0, 3 tick_adj -> 03:01.
- ADJUST, sel_sw=0, BLINK_EN=1, tick_2hz pulses -> blank alternates 4'b1100 / 4'b0000 on consecutive ticks, first value after entry 4'b0000; adj_sw=0 -> blank 0, state=PAUSED.
- RUNNING at 00:10, assert tick_1hz and pause_btn in the same cycle -> 00:11, state=PAUSED; then clr_btn with tick_1hz -> 00:00, STOPPED.
- RUNNING at 12:34, assert rst with pause_btn and tick_1hz -> next cycle all outputs at reset values, state=STOPPED.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

    localparam int DIGIT_W     = 4;
    localparam int SEC_MOD_DEF = 60;
    localparam int MIN_MOD_DEF = 60;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        ADJUST  = 2'd3
    } sw_state_e;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps MOD-1 -> 0; carry flags the wrapping increment.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'((MOD - 1) / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'((MOD - 1) % 10);

    logic [DIGIT_W-1:0] tens_r;
    logic [DIGIT_W-1:0] ones_r;
    logic               at_max_s;

    // Terminal-count detect done directly on the BCD digits.
    always_comb begin
        at_max_s = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
        carry    = inc & at_max_s;
    end

    // Digit registers: clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (inc) begin
            if (at_max_s) begin
                tens_r <= 4'd0;
                ones_r <= 4'd0;
            end else if (ones_r == 4'd9) begin
                tens_r <= tens_r + 4'd1;
                ones_r <= 4'd0;
            end else begin
                ones_r <= ones_r + 4'd1;
            end
        end else begin
            tens_r <= tens_r;
            ones_r <= ones_r;
        end
    end

    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/clear/adjust sequencing, MM:SS BCD time and blink mask.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_MOD  = SEC_MOD_DEF,
    parameter int MIN_MOD  = MIN_MOD_DEF,
    parameter int BLINK_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               tick_adj,
    input  logic               pause_btn,
    input  logic               clr_btn,
    input  logic               adj_sw,
    input  logic               sel_sw,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [3:0]         blank,
    output logic               running,
    output logic [1:0]         state,
    output logic               wrap
);

    sw_state_e  state_r, state_nxt_s;
    logic       blink_r, blink_nxt_s;
    logic [3:0] blank_r, blank_nxt_s;
    logic       running_r, wrap_r, wrap_nxt_s;
    logic       clr_s, sec_inc_s, min_inc_s, count_s;
    logic       sec_carry_s, min_carry_s;

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .rst(rst), .clr(clr_s), .inc(sec_inc_s),
        .tens(sec_tens), .ones(sec_ones), .carry(sec_carry_s)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .rst(rst), .clr(clr_s), .inc(min_inc_s),
        .tens(min_tens), .ones(min_ones), .carry(min_carry_s)
    );

    // Next state and counter enables, ordered clr > adj_sw > pause_btn > tick_1hz.
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = 1'b0;
        sec_inc_s   = 1'b0;
        min_inc_s   = 1'b0;
        count_s     = 1'b0;
        if (clr_btn) begin
            clr_s       = 1'b1;
            state_nxt_s = adj_sw ? ADJUST : STOPPED;
        end else if (adj_sw) begin
            state_nxt_s = ADJUST;
            if (state_r == ADJUST && tick_adj) begin
                sec_inc_s = sel_sw;
                min_inc_s = ~sel_sw;
            end else begin
                sec_inc_s = 1'b0;
            end
        end else if (state_r == ADJUST) begin
            state_nxt_s = PAUSED;
        end else begin
            // A tick in RUNNING counts even when pause_btn arrives the same cycle.
            count_s   = (state_r == RUNNING) && tick_1hz;
            sec_inc_s = count_s;
            min_inc_s = sec_carry_s;
            if (pause_btn) begin
                case (state_r)
                    STOPPED: state_nxt_s = RUNNING;
                    RUNNING: state_nxt_s = PAUSED;
                    PAUSED:  state_nxt_s = RUNNING;
                    default: state_nxt_s = STOPPED;
                endcase
            end else begin
                state_nxt_s = state_r;
            end
        end
    end

    // Blink phase, blank mask and rollover pulse, computed from next-cycle state.
    always_comb begin
        blink_nxt_s = blink_r;
        blank_nxt_s = 4'b0000;
        wrap_nxt_s  = count_s & sec_carry_s & min_carry_s;
        if (state_nxt_s == ADJUST && state_r != ADJUST) begin
            blink_nxt_s = 1'b0;
        end else if (tick_2hz) begin
            blink_nxt_s = ~blink_r;
        end else begin
            blink_nxt_s = blink_r;
        end
        if (BLINK_EN != 0 && state_nxt_s == ADJUST && blink_nxt_s) begin
            blank_nxt_s = sel_sw ? 4'b0011 : 4'b1100;
        end else begin
            blank_nxt_s = 4'b0000;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= STOPPED;
            blink_r   <= 1'b0;
            blank_r   <= 4'b0000;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            blink_r   <= blink_nxt_s;
            blank_r   <= blank_nxt_s;
            running_r <= (state_nxt_s == RUNNING);
            wrap_r    <= wrap_nxt_s;
        end
    end

    assign state   = state_r;
    assign blank   = blank_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule
